// File: rtl/phase_detector.sv
// Measures signed current-vs-voltage zero-cross lag and the voltage period in clk cycles.
// Optional macro PHASE_AVG_EN: phase_diff becomes the mean of the last four raw samples.
module phase_detector #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned TIMEOUT     = 32000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        v_zc,
  input  logic        i_zc,
  output logic [15:0] phase_diff,
  output logic [15:0] period,
  output logic        valid,
  output logic        no_signal,
  output logic        i_missing
);

  localparam logic [15:0] TimeoutCnt = 16'(TIMEOUT);

  typedef enum logic [0:0] {StIdle, StArm} state_e;

  logic [SYNC_STAGES-1:0] v_sync_q, i_sync_q;
  logic                   v_prev_q, i_prev_q;
  logic                   ev, ei;

  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] lag_q, lag_d;
  logic        i_seen_q, i_seen_d;
  logic [15:0] phase_q, phase_d;
  logic [15:0] period_q, period_d;
  logic        valid_q, valid_d;
  logic        no_signal_q, no_signal_d;
  logic        i_missing_q, i_missing_d;

  logic [15:0] raw_phase;
  logic        sample_vld;
  logic        out_ok;
  logic [15:0] out_phase;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v_sync_q <= '0;
      i_sync_q <= '0;
      v_prev_q <= 1'b0;
      i_prev_q <= 1'b0;
    end else begin
      v_sync_q <= {v_sync_q[SYNC_STAGES-2:0], v_zc};
      i_sync_q <= {i_sync_q[SYNC_STAGES-2:0], i_zc};
      v_prev_q <= v_sync_q[SYNC_STAGES-1];
      i_prev_q <= i_sync_q[SYNC_STAGES-1];
    end
  end

  assign ev = v_sync_q[SYNC_STAGES-1] & ~v_prev_q;
  assign ei = i_sync_q[SYNC_STAGES-1] & ~i_prev_q;

  // Lag beyond half a period is reported as a negative lead.
  always_comb begin
    if ({lag_q, 1'b0} <= {1'b0, cnt_q}) begin
      raw_phase = lag_q;
    end else begin
      raw_phase = 16'({1'b0, lag_q} - {1'b0, cnt_q});
    end
  end

`ifdef PHASE_AVG_EN
  logic        [15:0] hist_q [4];
  logic signed [17:0] sum_q, sum_d;
  logic        [2:0]  fill_q;

  assign sum_d = sum_q + 18'(signed'(raw_phase)) - 18'(signed'(hist_q[3]));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < 4; k++) hist_q[k] <= '0;
      sum_q  <= '0;
      fill_q <= '0;
    end else if (state_q == StIdle) begin
      for (int k = 0; k < 4; k++) hist_q[k] <= '0;
      sum_q  <= '0;
      fill_q <= '0;
    end else if (sample_vld) begin
      hist_q[0] <= raw_phase;
      for (int k = 1; k < 4; k++) hist_q[k] <= hist_q[k-1];
      sum_q  <= sum_d;
      fill_q <= (fill_q == 3'd4) ? fill_q : fill_q + 3'd1;
    end
  end

  // This sample is the fourth (or later) one in the history.
  assign out_ok    = (fill_q >= 3'd3);
  assign out_phase = 16'(sum_d >>> 2);
`else
  assign out_ok    = 1'b1;
  assign out_phase = raw_phase;
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    lag_d       = lag_q;
    i_seen_d    = i_seen_q;
    phase_d     = phase_q;
    period_d    = period_q;
    valid_d     = 1'b0;
    no_signal_d = no_signal_q;
    i_missing_d = i_missing_q;
    sample_vld  = 1'b0;

    if (ev) begin
      cnt_d = 16'd1;
    end else if (cnt_q != TimeoutCnt) begin
      cnt_d = cnt_q + 16'd1;
    end

    if (!enable) begin
      state_d = StIdle;
    end else begin
      case (state_q)
        StIdle: begin
          if (ev) begin
            state_d  = StArm;
            i_seen_d = 1'b0;
            lag_d    = '0;
          end
        end
        StArm: begin
          if (ev) begin
            no_signal_d = 1'b0;
            if (i_seen_q) begin
              sample_vld  = 1'b1;
              period_d    = cnt_q;
              i_missing_d = 1'b0;
            end else begin
              i_missing_d = 1'b1;
            end
            // A current edge coincident with ev belongs to the new period at zero lag.
            i_seen_d = ei;
            lag_d    = '0;
          end else if (cnt_q == TimeoutCnt) begin
            state_d     = StIdle;
            no_signal_d = 1'b1;
            phase_d     = '0;
            i_missing_d = 1'b0;
          end else if (ei && !i_seen_q) begin
            lag_d    = cnt_q;
            i_seen_d = 1'b1;
          end
        end
        default: state_d = StIdle;
      endcase
    end

    if (sample_vld && out_ok) begin
      phase_d = out_phase;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      lag_q       <= '0;
      i_seen_q    <= 1'b0;
      phase_q     <= '0;
      period_q    <= '0;
      valid_q     <= 1'b0;
      no_signal_q <= 1'b1;
      i_missing_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      lag_q       <= lag_d;
      i_seen_q    <= i_seen_d;
      phase_q     <= phase_d;
      period_q    <= period_d;
      valid_q     <= valid_d;
      no_signal_q <= no_signal_d;
      i_missing_q <= i_missing_d;
    end
  end

  assign phase_diff = phase_q;
  assign period     = period_q;
  assign valid      = valid_q;
  assign no_signal  = no_signal_q;
  assign i_missing  = i_missing_q;

endmodule

// File: tb/tb_phase_detector.sv
// Scoreboard bench for phase_detector: stimulus pushes expected events, a monitor pops them.
module tb_phase_detector;

  localparam int unsigned SyncStages = 2;
  localparam int unsigned Timeout    = 32000;

  localparam int KValid = 0;
  localparam int KMiss  = 1;
  localparam int KNoSig = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic        v_zc;
  logic        i_zc;
  logic [15:0] phase_diff;
  logic [15:0] period;
  logic        valid;
  logic        no_signal;
  logic        i_missing;

  phase_detector #(
    .SYNC_STAGES(SyncStages),
    .TIMEOUT    (Timeout)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .enable    (enable),
    .v_zc      (v_zc),
    .i_zc      (i_zc),
    .phase_diff(phase_diff),
    .period    (period),
    .valid     (valid),
    .no_signal (no_signal),
    .i_missing (i_missing)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    int kind;
    int phase;
    int per;
    int at_cyc;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  // Reference model state
  bit   open = 1'b0;
  int   open_p, open_lag;
  bit   open_seen;
  int   m_phase = 0, m_per = 0;
  bit   m_imiss = 1'b0;
  int   hist[$];
  int   last_edge_cyc = 0;

  task automatic check(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic push(input int kind, input int ph, input int per, input int at);
    exp_t e;
    e.kind = kind; e.phase = ph; e.per = per; e.at_cyc = at;
    sb.push_back(e);
  endtask

  // Close the open period at a voltage rising edge.
  task automatic model_eval();
    int raw;
    if (!open) return;
    if (open_seen) begin
      raw     = (2 * open_lag <= open_p) ? open_lag : open_lag - open_p;
      m_imiss = 1'b0;
      m_per   = open_p;
      hist.push_back(raw);
      if (hist.size() > 4) void'(hist.pop_front());
`ifdef PHASE_AVG_EN
      if (hist.size() == 4) begin
        m_phase = (hist[0] + hist[1] + hist[2] + hist[3]) >>> 2;
        push(KValid, m_phase, m_per, 0);
      end
`else
      m_phase = raw;
      push(KValid, m_phase, m_per, 0);
`endif
    end else if (!m_imiss) begin
      m_imiss = 1'b1;
      push(KMiss, m_phase, m_per, 0);
    end
  endtask

  task automatic check_reset_outputs();
    check("rst_phase_diff", int'(phase_diff), 0);
    check("rst_period", int'(period), 0);
    check("rst_valid", int'(valid), 0);
    check("rst_no_signal", int'(no_signal), 1);
    check("rst_i_missing", int'(i_missing), 0);
  endtask

  task automatic model_reset();
    open    = 1'b0;
    hist.delete();
    m_phase = 0;
    m_per   = 0;
    m_imiss = 1'b0;
  endtask

  // One voltage period of p cycles; d/d2 are current rising offsets (-1 = none).
  task automatic run_period(input int p, input int d, input int d2, input int en_off,
                            input int rst_at);
    int w;
    bit first;
    w = (d >= 0) ? ((p - d - 1 < 10) ? p - d - 1 : 10) : 0;
    for (int c = 0; c < p; c++) begin
      @(posedge clk); #1;
      if (c == 0) begin
        model_eval();
        last_edge_cyc = cyc;
        first         = !open;
        open          = 1'b1;
        open_p        = p;
        if (d >= 0 && (d > 0 || !first)) begin
          open_seen = 1'b1; open_lag = d;
        end else if (d2 >= 0) begin
          open_seen = 1'b1; open_lag = d2;
        end else begin
          open_seen = 1'b0; open_lag = 0;
        end
      end
      v_zc   = (c < p / 2);
      i_zc   = (d >= 0 && c >= d && c < d + w) || (d2 >= 0 && c == d2);
      enable = !(en_off >= 0 && c >= en_off && c < en_off + 10);
      if (c == rst_at) begin
        rst = 1'b1;
        #1;
        check_reset_outputs();
        v_zc = 1'b0;
        i_zc = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        return;
      end
    end
    if (en_off >= 0) begin
      open = 1'b0;
      hist.delete();
    end
  endtask

  task automatic run_random(input int n);
    int p, d, d2, w;
    for (int k = 0; k < n; k++) begin
      p  = int'($urandom_range(50, 1000));
      d  = ($urandom_range(0, 5) == 0) ? -1 : int'($urandom_range(0, p - 2));
      d2 = -1;
      if (d >= 0) begin
        w = (p - d - 1 < 10) ? p - d - 1 : 10;
        if (d + w + 2 <= p - 2 && $urandom_range(0, 3) == 0)
          d2 = int'($urandom_range(d + w + 2, p - 2));
      end
      run_period(p, d, d2, -1, -1);
    end
  endtask

  task automatic silence_timeout();
    @(posedge clk); #1;
    v_zc = 1'b0;
    i_zc = 1'b0;
    push(KNoSig, 0, 0, last_edge_cyc + SyncStages + 1 + Timeout);
    repeat (Timeout + 40) @(posedge clk);
    #1;
    check("timeout_event_seen", sb.size(), 0);
    open    = 1'b0;
    hist.delete();
    m_phase = 0;
    m_imiss = 1'b0;
  endtask

  task automatic pop_cmp(input int kind);
    exp_t e;
    if (sb.size() == 0) begin
      check("unexpected_output_event", kind, -1);
      return;
    end
    e = sb.pop_front();
    check("event_kind", kind, e.kind);
    if (kind == KValid) begin
      check("valid_phase_diff", int'($signed(phase_diff)), e.phase);
      check("valid_period", int'(period), e.per);
      check("valid_i_missing", int'(i_missing), 0);
      check("valid_no_signal", int'(no_signal), 0);
    end else if (kind == KMiss) begin
      check("miss_phase_hold", int'($signed(phase_diff)), e.phase);
      check("miss_period_hold", int'(period), e.per);
      check("miss_no_signal", int'(no_signal), 0);
    end else begin
      check("nosig_cycle", int'(cyc), e.at_cyc);
      check("nosig_phase_diff", int'(phase_diff), 0);
      check("nosig_i_missing", int'(i_missing), 0);
    end
  endtask

  bit valid_prev = 1'b0, imiss_prev = 1'b0, nosig_prev = 1'b1;

  always @(negedge clk) begin
    if (rst === 1'b0) begin
      if (valid) begin
        check("valid_not_back_to_back", int'(valid_prev), 0);
        pop_cmp(KValid);
      end
      if (i_missing && !imiss_prev) pop_cmp(KMiss);
      if (no_signal && !nosig_prev) pop_cmp(KNoSig);
    end
    valid_prev = valid;
    imiss_prev = i_missing;
    nosig_prev = no_signal;
  end

  initial begin
    rst    = 1'b1;
    enable = 1'b1;
    v_zc   = 1'b0;
    i_zc   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs();
    rst = 1'b0;

    // Current lagging by 100, then leading by 100, then the half-period boundary.
    repeat (4) run_period(1000, 100, -1, -1, -1);
    repeat (3) run_period(1000, 900, -1, -1, -1);
    run_period(1000, 500, -1, -1, -1);
    run_period(1000, 501, -1, -1, -1);
    // Coincident edges, with an extra ignored current pulse.
    run_period(1000, 0, -1, -1, -1);
    run_period(1000, 0, 50, -1, -1);
    run_period(1000, 0, 50, -1, -1);
    // One period with no current edge, then resume.
    run_period(1000, -1, -1, -1, -1);
    repeat (3) run_period(1000, 100, -1, -1, -1);

    run_random(12);
    run_period(800, 200, -1, 400, -1);
    run_random(4);

    silence_timeout();
    repeat (3) run_period(1000, 100, -1, -1, -1);

    run_period(1000, 100, -1, -1, 500);
    run_period(1000, 100, -1, -1, -1);
    run_period(1000, 100, -1, -1, -1);
    run_period(1000, 100, -1, -1, -1);
    run_period(1000, 104, -1, -1, -1);
    run_period(1000, 100, -1, -1, -1);

    @(posedge clk); #1;
    v_zc = 1'b0;
    i_zc = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    check("scoreboard_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
